// File: rtl/project_pwm_pkg.sv
// Shared definitions for the PWM sync controller and its period-counter slaves:
// mode codes, shadow register offsets and controller state encodings.
package project_pwm_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_UP      = 2'b01;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  localparam logic [1:0] MODE_UP_DOWN = 2'b11;

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_PHASE  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // True when a shadow write addresses a real register of channel ch.
  function automatic logic wr_hits(input logic [3:0] addr, input logic [1:0] ch);
    return (addr[3:2] == ch) && (addr[1:0] != REG_RSVD);
  endfunction

endpackage

// File: rtl/project_pwm_channel_regs.sv
// One channel's shadow (CPU-written) and active (slave-facing) configuration.
// Active registers change only on i_xfer, which copies every shadow field.
module project_pwm_channel_regs
  import project_pwm_pkg::*;
#(
  parameter int         W      = 16,
  parameter logic [1:0] CH_IDX = 2'd0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_wr_en,
  input  logic [3:0]   i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_xfer,
  output logic [W-1:0] o_period,
  output logic [W-1:0] o_phase,
  output logic [1:0]   o_mode,
  output logic         o_sync_en
);

  logic [W-1:0] sh_period_q, sh_period_d;
  logic [W-1:0] sh_phase_q,  sh_phase_d;
  logic [1:0]   sh_mode_q,   sh_mode_d;
  logic         sh_sync_en_q, sh_sync_en_d;
  logic [W-1:0] ac_period_q, ac_period_d;
  logic [W-1:0] ac_phase_q,  ac_phase_d;
  logic [1:0]   ac_mode_q,   ac_mode_d;
  logic         ac_sync_en_q, ac_sync_en_d;

  // Next-state for shadow writes and shadow-to-active transfer.
  always_comb begin
    sh_period_d  = sh_period_q;
    sh_phase_d   = sh_phase_q;
    sh_mode_d    = sh_mode_q;
    sh_sync_en_d = sh_sync_en_q;
    if (i_wr_en && wr_hits(i_wr_addr, CH_IDX)) begin
      case (i_wr_addr[1:0])
        REG_PERIOD: sh_period_d = i_wr_data;
        REG_PHASE:  sh_phase_d  = i_wr_data;
        REG_CTRL: begin
          sh_mode_d    = i_wr_data[1:0];
          sh_sync_en_d = i_wr_data[2];
        end
        default: sh_period_d = sh_period_q;
      endcase
    end else begin
      sh_period_d = sh_period_q;
    end

    // Transfer takes the shadow value held before any same-cycle write.
    if (i_xfer) begin
      ac_period_d  = sh_period_q;
      ac_phase_d   = sh_phase_q;
      ac_mode_d    = sh_mode_q;
      ac_sync_en_d = sh_sync_en_q;
    end else begin
      ac_period_d  = ac_period_q;
      ac_phase_d   = ac_phase_q;
      ac_mode_d    = ac_mode_q;
      ac_sync_en_d = ac_sync_en_q;
    end
  end

  // Shadow and active register storage.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sh_period_q  <= {W{1'b0}};
      sh_phase_q   <= {W{1'b0}};
      sh_mode_q    <= MODE_OFF;
      sh_sync_en_q <= 1'b0;
      ac_period_q  <= {W{1'b0}};
      ac_phase_q   <= {W{1'b0}};
      ac_mode_q    <= MODE_OFF;
      ac_sync_en_q <= 1'b0;
    end else begin
      sh_period_q  <= sh_period_d;
      sh_phase_q   <= sh_phase_d;
      sh_mode_q    <= sh_mode_d;
      sh_sync_en_q <= sh_sync_en_d;
      ac_period_q  <= ac_period_d;
      ac_phase_q   <= ac_phase_d;
      ac_mode_q    <= ac_mode_d;
      ac_sync_en_q <= ac_sync_en_d;
    end
  end

  assign o_period  = ac_period_q;
  assign o_phase   = ac_phase_q;
  assign o_mode    = ac_mode_q;
  assign o_sync_en = ac_sync_en_q;

endmodule

// File: rtl/project_pwm_sync_controller.sv
// Start/stop sequencer for up to four period-counter slaves with commit of new
// configuration aligned to the master period boundary, optionally re-phasing.
module project_pwm_sync_controller
  import project_pwm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_wr_en,
  input  logic [3:0]          i_wr_addr,
  input  logic [W-1:0]        i_wr_data,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_commit,
  input  logic                i_commit_resync,
  input  logic                i_master_sync,
  output logic                o_en,
  output logic [N_CH-1:0]     o_phase_en,
  output logic [2*N_CH-1:0]   o_mode,
  output logic [W*N_CH-1:0]   o_period,
  output logic [W*N_CH-1:0]   o_phase,
  output logic [N_CH-1:0]     o_sync_en,
  output logic                o_busy,
  output logic                o_commit_pending,
  output logic                o_commit_done
);

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic            resync_q, resync_d;
  logic            done_q, done_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [N_CH-1:0] phase_en_q, phase_en_d;
  logic            xfer_s;

  // Sequencing: start, one-cycle load, run with boundary-aligned commits; stop wins.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    resync_d  = resync_q;
    done_d    = 1'b0;
    xfer_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          xfer_s  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_stop) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
          resync_d  = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
          resync_d  = 1'b0;
        end else begin
          if (pending_q && i_master_sync) begin
            xfer_s    = 1'b1;
            pending_d = 1'b0;
            done_d    = 1'b1;
            if (resync_q) begin
              state_d  = ST_LOAD;
              resync_d = 1'b0;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
          // A commit arriving on the sync cycle is queued for the next boundary.
          if (i_commit) begin
            pending_d = 1'b1;
            resync_d  = resync_d | i_commit_resync;
          end else begin
            pending_d = pending_d;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
        resync_d  = 1'b0;
      end
    endcase

    en_d       = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    phase_en_d = {N_CH{state_d == ST_LOAD}};
  end

  // Controller state and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      resync_q   <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      phase_en_q <= {N_CH{1'b0}};
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      resync_q   <= resync_d;
      done_q     <= done_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      phase_en_q <= phase_en_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    project_pwm_channel_regs #(
      .W      (W),
      .CH_IDX (2'(k))
    ) u_regs (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_xfer    (xfer_s),
      .o_period  (o_period[W*k +: W]),
      .o_phase   (o_phase[W*k +: W]),
      .o_mode    (o_mode[2*k +: 2]),
      .o_sync_en (o_sync_en[k])
    );
  end

  assign o_en             = en_q;
  assign o_busy           = busy_q;
  assign o_phase_en       = phase_en_q;
  assign o_commit_pending = pending_q;
  assign o_commit_done    = done_q;

endmodule

// File: tb/tb_project_pwm_sync_controller.sv
// Self-checking bench: a 4-channel and a 2-channel controller share stimulus and
// are compared every cycle against a behavioural model of the controller.
module tb_project_pwm_sync_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'd0;
  logic        start = 1'b0, stop = 1'b0, commit = 1'b0, resync = 1'b0, msync = 1'b0;

  logic        en4, busy4, pend4, done4;
  logic [3:0]  phen4, sen4;
  logic [7:0]  mode4;
  logic [63:0] per4, ph4;
  logic        en2, busy2, pend2, done2;
  logic [1:0]  phen2, sen2;
  logic [3:0]  mode2;
  logic [31:0] per2, ph2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  project_pwm_sync_controller #(.N_CH(4), .W(16)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_commit(commit),
    .i_commit_resync(resync), .i_master_sync(msync), .o_en(en4),
    .o_phase_en(phen4), .o_mode(mode4), .o_period(per4), .o_phase(ph4),
    .o_sync_en(sen4), .o_busy(busy4), .o_commit_pending(pend4),
    .o_commit_done(done4));

  project_pwm_sync_controller #(.N_CH(2), .W(16)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_commit(commit),
    .i_commit_resync(resync), .i_master_sync(msync), .o_en(en2),
    .o_phase_en(phen2), .o_mode(mode2), .o_period(per2), .o_phase(ph2),
    .o_sync_en(sen2), .o_busy(busy2), .o_commit_pending(pend2),
    .o_commit_done(done2));

  // Reference model: configuration tables plus an activity phase.
  localparam int P_STOPPED = 0, P_LOADING = 1, P_RUNNING = 2;
  logic [15:0] m_sh_per [4], m_sh_ph [4], m_ac_per [4], m_ac_ph [4];
  logic [1:0]  m_sh_mode [4], m_ac_mode [4];
  logic        m_sh_se [4], m_ac_se [4];
  int          m_phase;
  bit          m_pend, m_rs, m_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_sh_per[k] = 16'd0; m_sh_ph[k] = 16'd0; m_sh_mode[k] = 2'd0; m_sh_se[k] = 1'b0;
      m_ac_per[k] = 16'd0; m_ac_ph[k] = 16'd0; m_ac_mode[k] = 2'd0; m_ac_se[k] = 1'b0;
    end
    m_phase = P_STOPPED; m_pend = 1'b0; m_rs = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    bit copy = 1'b0;
    int ch;
    m_done = 1'b0;
    if (m_phase == P_STOPPED) begin
      if (start) begin copy = 1'b1; m_phase = P_LOADING; end
    end else if (stop) begin
      m_phase = P_STOPPED; m_pend = 1'b0; m_rs = 1'b0;
    end else if (m_phase == P_LOADING) begin
      m_phase = P_RUNNING;
    end else begin
      if (m_pend && msync) begin
        copy = 1'b1; m_pend = 1'b0; m_done = 1'b1;
        if (m_rs) begin m_phase = P_LOADING; m_rs = 1'b0; end
      end
      if (commit) begin m_pend = 1'b1; m_rs = m_rs | resync; end
    end
    if (copy) begin
      for (int k = 0; k < 4; k++) begin
        m_ac_per[k] = m_sh_per[k]; m_ac_ph[k] = m_sh_ph[k];
        m_ac_mode[k] = m_sh_mode[k]; m_ac_se[k] = m_sh_se[k];
      end
    end
    if (wr_en) begin
      ch = int'(wr_addr[3:2]);
      if (wr_addr[1:0] == 2'd0) m_sh_per[ch] = wr_data;
      else if (wr_addr[1:0] == 2'd1) m_sh_ph[ch] = wr_data;
      else if (wr_addr[1:0] == 2'd2) begin
        m_sh_mode[ch] = wr_data[1:0]; m_sh_se[ch] = wr_data[2];
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] e_per, e_ph;
    logic [7:0]  e_mode;
    logic [3:0]  e_se;
    bit          active, loading;
    for (int k = 0; k < 4; k++) begin
      e_per[16*k +: 16] = m_ac_per[k];
      e_ph[16*k +: 16]  = m_ac_ph[k];
      e_mode[2*k +: 2]  = m_ac_mode[k];
      e_se[k]           = m_ac_se[k];
    end
    active  = (m_phase != P_STOPPED);
    loading = (m_phase == P_LOADING);
    check_eq("en4", 64'(en4), 64'(active));
    check_eq("busy4", 64'(busy4), 64'(active));
    check_eq("phase_en4", 64'(phen4), loading ? 64'hF : 64'h0);
    check_eq("pending4", 64'(pend4), 64'(m_pend));
    check_eq("done4", 64'(done4), 64'(m_done));
    check_eq("period4", per4, e_per);
    check_eq("phase4", ph4, e_ph);
    check_eq("mode4", 64'(mode4), 64'(e_mode));
    check_eq("sync_en4", 64'(sen4), 64'(e_se));
    check_eq("en2", 64'(en2), 64'(active));
    check_eq("busy2", 64'(busy2), 64'(active));
    check_eq("phase_en2", 64'(phen2), loading ? 64'h3 : 64'h0);
    check_eq("pending2", 64'(pend2), 64'(m_pend));
    check_eq("done2", 64'(done2), 64'(m_done));
    check_eq("period2", 64'(per2), 64'(e_per[31:0]));
    check_eq("phase2", 64'(ph2), 64'(e_ph[31:0]));
    check_eq("mode2", 64'(mode2), 64'(e_mode[3:0]));
    check_eq("sync_en2", 64'(sen2), 64'(e_se[1:0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    wr_en = 1'b0; start = 1'b0; stop = 1'b0; commit = 1'b0; resync = 1'b0; msync = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // Initial configuration and start.
    wr(4'h0, 16'd9);
    wr(4'h2, 16'h0005);
    wr(4'h4, 16'd9);
    wr(4'h5, 16'd5);
    wr(4'h6, 16'h0002);
    start = 1'b1; step();
    check_eq("tp_load_phase_en", 64'(phen4), 64'hF);
    check_eq("tp_load_en", 64'(en4), 64'h1);
    step();
    check_eq("tp_run_phase_en", 64'(phen4), 64'h0);
    check_eq("tp_run_period0", 64'(per4[15:0]), 64'd9);
    check_eq("tp_run_phase1", 64'(ph4[31:16]), 64'd5);
    check_eq("tp_run_mode0", 64'(mode4[1:0]), 64'h1);

    // Plain commit on the boundary.
    wr(4'h0, 16'd19);
    commit = 1'b1; step();
    check_eq("tp_pending", 64'(pend4), 64'h1);
    check_eq("tp_period_held", 64'(per4[15:0]), 64'd9);
    step();
    msync = 1'b1; step();
    check_eq("tp_commit_period", 64'(per4[15:0]), 64'd19);
    check_eq("tp_commit_done", 64'(done4), 64'h1);
    check_eq("tp_commit_no_reload", 64'(phen4), 64'h0);
    step();
    check_eq("tp_done_once", 64'(done4), 64'h0);

    // Resync commit: one reload cycle.
    commit = 1'b1; resync = 1'b1; step();
    msync = 1'b1; step();
    check_eq("tp_resync_load", 64'(phen4), 64'hF);
    step();
    check_eq("tp_resync_run", 64'(phen4), 64'h0);

    // Stop beats a pending commit on the boundary.
    wr(4'h0, 16'd77);
    commit = 1'b1; step();
    stop = 1'b1; msync = 1'b1; step();
    check_eq("tp_stop_en", 64'(en4), 64'h0);
    check_eq("tp_stop_pending", 64'(pend4), 64'h0);
    check_eq("tp_stop_done", 64'(done4), 64'h0);
    check_eq("tp_stop_period", 64'(per4[15:0]), 64'd19);

    // Ignored writes and IDLE commit.
    wr(4'hF, 16'hFFFF);
    wr(4'h3, 16'hABCD);
    wr(4'hC, 16'd123);
    wr(4'hE, 16'h0007);
    commit = 1'b1; step();
    check_eq("tp_idle_commit", 64'(pend4), 64'h0);
    start = 1'b1; stop = 1'b1; step();
    check_eq("tp_start_wins", 64'(en4), 64'h1);
    step();

    // Asynchronous reset with a commit pending.
    commit = 1'b1; step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("tp_rst_en", 64'(en4), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1; step();
    step();
    check_eq("tp_zero_mode", 64'(mode4), 64'h0);
    check_eq("tp_zero_period", per4, 64'h0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      commit  = ($urandom_range(0, 6) == 0);
      resync  = ($urandom_range(0, 1) == 1);
      msync   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
